// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared mode encoding and width helpers for the pooling engine
package pool_pkg;

  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_t;

  function automatic int acc_width(input int dw, input int win_log2);
    return dw + win_log2;
  endfunction

endpackage

// File: rtl/pool_lane.sv
// rtl/pool_lane.sv - one channel of window reduction: accumulator plus AVG/MAX result path
module pool_lane
  import pool_pkg::*;
#(
  parameter int DW       = 16,
  parameter int WIN_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load_i,
  input  logic                 first_i,
  input  logic                 last_i,
  input  pool_mode_t           mode_i,
  input  logic signed [DW-1:0] din_i,
  output logic signed [DW-1:0] result_o
);

  localparam int AW = acc_width(DW, WIN_LOG2);

  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_d;
  logic signed [AW-1:0] din_ext;
  logic signed [AW-1:0] max_v;
  logic signed [AW:0]   sum_rnd;
  logic signed [AW:0]   avg_full;

  assign din_ext = {{WIN_LOG2{din_i[DW-1]}}, din_i};
  assign max_v   = (din_ext > acc_q) ? din_ext : acc_q;

  // One guard bit on top of AW keeps the rounding add trivially overflow-free.
  assign sum_rnd  = {acc_q[AW-1], acc_q} + {din_ext[AW-1], din_ext}
                  + (AW+1)'(1 << (WIN_LOG2 - 1));
  assign avg_full = sum_rnd >>> WIN_LOG2;

  assign result_o = (mode_i == POOL_MAX) ? DW'(max_v) : DW'(avg_full);

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      if (first_i) begin
        acc_d = din_ext;
      end else if (!last_i) begin
        acc_d = (mode_i == POOL_MAX) ? max_v : (acc_q + din_ext);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pool_stream_engine.sv
// rtl/pool_stream_engine.sv - streaming CH-channel window pooling with valid/ready and one-entry output buffer
module pool_stream_engine
  import pool_pkg::*;
#(
  parameter int CH       = 64,
  parameter int DW       = 16,
  parameter int WIN_LOG2 = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               mode,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH*DW-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH*DW-1:0]   out_data,
  output logic [15:0]        win_done_cnt
);

  logic [WIN_LOG2-1:0] elem_cnt_q, elem_cnt_d;
  pool_mode_t          mode_q, mode_d;
  logic                out_valid_q, out_valid_d;
  logic [CH*DW-1:0]    out_data_q, out_data_d;
  logic [15:0]         win_cnt_q, win_cnt_d;
  logic [CH*DW-1:0]    lane_res;

  logic is_first;
  logic is_last;
  logic accept;
  logic load_out;

  assign is_first = (elem_cnt_q == '0);
  assign is_last  = &elem_cnt_q;

  // Only the closing beat needs buffer space; it waits while the buffer is full and not draining.
  assign in_ready = !clear && !(is_last && out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign load_out = accept && is_last;

  for (genvar c = 0; c < CH; c++) begin : g_lane
    pool_lane #(
      .DW       (DW),
      .WIN_LOG2 (WIN_LOG2)
    ) u_lane (
      .clk      (clk),
      .rstn     (rstn),
      .load_i   (accept),
      .first_i  (is_first),
      .last_i   (is_last),
      .mode_i   (mode_q),
      .din_i    (in_data[c*DW +: DW]),
      .result_o (lane_res[c*DW +: DW])
    );
  end

  always_comb begin
    elem_cnt_d  = elem_cnt_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    win_cnt_d   = win_cnt_q;

    if (clear) begin
      elem_cnt_d = '0;
    end else if (accept) begin
      elem_cnt_d = elem_cnt_q + WIN_LOG2'(1);
    end

    if (accept && is_first) begin
      mode_d = pool_mode_t'(mode);
    end

    // A result loading in the same cycle as a drain replaces the drained one.
    if (load_out) begin
      out_valid_d = 1'b1;
      out_data_d  = lane_res;
      win_cnt_d   = win_cnt_q + 16'd1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      elem_cnt_q  <= '0;
      mode_q      <= POOL_AVG;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      win_cnt_q   <= '0;
    end else begin
      elem_cnt_q  <= elem_cnt_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      win_cnt_q   <= win_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign win_done_cnt = win_cnt_q;

endmodule

// File: tb/tb_pool_stream_engine.sv
// tb/tb_pool_stream_engine.sv - directed self-checking bench for pool_stream_engine (CH=2, DW=16, 2x2 window)
module tb_pool_stream_engine;

  localparam int CH = 2;
  localparam int DW = 16;
  localparam int WL = 2;

  logic             clk = 1'b0;
  logic             rstn;
  logic             mode;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [CH*DW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CH*DW-1:0] out_data;
  logic [15:0]      win_done_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pool_stream_engine #(
    .CH       (CH),
    .DW       (DW),
    .WIN_LOG2 (WL)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .mode         (mode),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .win_done_cnt (win_done_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ch(input int c);
    logic signed [DW-1:0] v;
    v = out_data[c*DW +: DW];
    return int'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d0, input int d1, input logic m);
    logic [DW-1:0] v0, v1;
    v0 = DW'(d0);
    v1 = DW'(d1);
    in_data = {v1, v0};
    mode    = m;
  endtask

  task automatic push(input int d0, input int d1, input logic m);
    int n;
    n = 0;
    in_valid = 1'b1;
    drive(d0, d1, m);
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("push_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; mode = 1'b0; clear = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1;
    tick(); tick();
    rstn = 1'b1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_win_cnt", int'(win_done_cnt), 0);
    check("rst_in_ready", int'(in_ready), 1);

    // AVG basic
    push(10, -1, 1'b0); push(20, -2, 1'b0); push(30, -3, 1'b0);
    check("avg_not_early", int'(out_valid), 0);
    push(41, -4, 1'b0);
    check("avg_valid", int'(out_valid), 1);
    check("avg_ch0", ch(0), 25);
    check("avg_ch1", ch(1), -2);
    check("avg_cnt", int'(win_done_cnt), 1);
    tick();
    check("avg_drained", int'(out_valid), 0);

    // MAX, mode change mid-window ignored
    push(-5, -32768, 1'b1); push(7, -32768, 1'b0);
    push(3, -32768, 1'b1); push(-100, -32768, 1'b1);
    check("max_ch0", ch(0), 7);
    check("max_ch1", ch(1), -32768);
    check("max_cnt", int'(win_done_cnt), 2);
    tick();

    // Backpressure
    out_ready = 1'b0;
    push(1, 5, 1'b0); push(2, 5, 1'b0); push(3, 5, 1'b0); push(4, 5, 1'b0);
    check("bp_w1_ch0", ch(0), 3);
    check("bp_w1_ch1", ch(1), 5);
    push(8, -8, 1'b0); push(8, -8, 1'b0); push(8, -8, 1'b0);
    in_valid = 1'b1;
    drive(8, -8, 1'b0);
    #1;
    check("bp_stall", int'(in_ready), 0);
    tick();
    check("bp_stall2", int'(in_ready), 0);
    check("bp_hold_ch0", ch(0), 3);
    check("bp_hold_cnt", int'(win_done_cnt), 3);
    out_ready = 1'b1;
    #1;
    check("bp_release", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("bp_w2_valid", int'(out_valid), 1);
    check("bp_w2_ch0", ch(0), 8);
    check("bp_w2_ch1", ch(1), -8);
    check("bp_w2_cnt", int'(win_done_cnt), 4);
    tick();
    check("bp_no_dup", int'(out_valid), 0);

    // AVG extremes and rounding
    for (int i = 0; i < 4; i++) push(32767, -32768, 1'b0);
    check("ext_max", ch(0), 32767);
    check("ext_min", ch(1), -32768);
    push(1, -1, 1'b0); push(1, -1, 1'b0); push(0, 0, 1'b0); push(0, 0, 1'b0);
    check("rnd_pos", ch(0), 1);
    check("rnd_neg", ch(1), 0);
    check("ext_cnt", int'(win_done_cnt), 6);
    tick();

    // clear with a buffered result
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(40, -40, 1'b0);
    push(1000, 1000, 1'b0); push(1000, 1000, 1'b0);
    clear = 1'b1; in_valid = 1'b1;
    drive(999, 999, 1'b0);
    #1;
    check("clr_in_ready", int'(in_ready), 0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("clr_keep_valid", int'(out_valid), 1);
    check("clr_keep_ch0", ch(0), 40);
    check("clr_keep_ch1", ch(1), -40);
    check("clr_keep_cnt", int'(win_done_cnt), 7);
    out_ready = 1'b1;
    tick();
    check("clr_drained", int'(out_valid), 0);
    push(2, -2, 1'b0); push(4, -4, 1'b0); push(6, -6, 1'b0);
    check("clr_not_early", int'(out_valid), 0);
    push(8, -9, 1'b0);
    check("clr_fresh_ch0", ch(0), 5);
    check("clr_fresh_ch1", ch(1), -5);
    check("clr_fresh_cnt", int'(win_done_cnt), 8);
    tick();

    // reset mid-window with a buffered result
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(1, 2, 1'b0);
    check("pre_rst_valid", int'(out_valid), 1);
    push(50, 50, 1'b1); push(50, 50, 1'b1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("mrst_valid", int'(out_valid), 0);
    check("mrst_data", int'(out_data), 0);
    check("mrst_cnt", int'(win_done_cnt), 0);
    out_ready = 1'b1;
    push(12, -3, 1'b0); push(0, -3, 1'b0); push(0, -3, 1'b0);
    check("mrst_not_early", int'(out_valid), 0);
    push(0, -3, 1'b0);
    check("mrst_ch0", ch(0), 3);
    check("mrst_ch1", ch(1), -3);
    check("mrst_cnt2", int'(win_done_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
